// File: rtl/ttl_test_pkg.sv
// Shared types and constants for the TTL test sequencer.
//   state_t   : sequencer FSM states
//   FALL_EDGE : {history, current} pattern of a falling edge
//   RISE_EDGE : {history, current} pattern of a rising edge (1 MHz tick)
//   cnt_t     : edge count at the default counter width
package ttl_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        EVAL,
        DONE
    } state_t;

    localparam logic [1:0] FALL_EDGE = 2'b10;
    localparam logic [1:0] RISE_EDGE = 2'b01;

    localparam int unsigned CNT_W_DEFAULT = 8;
    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/ttl_edge_counter.sv
// Falling-edge counter for the currently selected, already synchronized TTL line.
// Ports:
//   clk_100Mz, rst : clock, async active-high reset
//   din            : selected synchronized TTL line
//   reload         : high in the first cycle after a channel switch; suppresses edge detect
//   clr            : synchronous clear of the count (priority over en)
//   en             : count falling edges while high
//   cnt            : saturating falling-edge count
module ttl_edge_counter
    import ttl_test_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_100Mz,
    input  logic             rst,
    input  logic             din,
    input  logic             reload,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic hist;
    logic fall_c;

    // History still holds the previous channel right after a switch, so that cycle is masked.
    assign fall_c = ({hist, din} == FALL_EDGE) && !reload;

    // History register and saturating counter
    always_ff @(posedge clk_100Mz or posedge rst) begin
        if (rst) begin
            hist <= 1'b0;
            cnt  <= '0;
        end else begin
            hist <= din;
            if (clr) begin
                cnt <= '0;
            end else if (en && fall_c && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ttl_test_sequencer.sv
// Walks the enabled TTL channels in ascending order through one shared falling-edge
// counter: settle window, measurement window, limit check, per-channel result, pass mask.
// Optional build macro: TTL_SEQ_STOP_ON_FAIL_EN - a failing channel ends the sequence.
// Ports:
//   clk_100Mz, rst      : clock, async active-high reset
//   clk_1Mz             : 1 MHz time base (rising edge after sync = tick)
//   ttl_in              : asynchronous TTL test lines
//   start, abort        : single-cycle control pulses
//   chan_en, exp_min/max: channel mask and inclusive limits, captured at start
//   busy, ch_sel        : sequence active, channel routed to the counter
//   res_valid/ch/cnt/pass: per-channel result strobe and held result
//   done, pass_mask     : completion pulse and per-channel pass bits
module ttl_test_sequencer
    import ttl_test_pkg::*;
#(
    parameter  int unsigned N_CH      = 8,
    parameter  int unsigned CNT_W     = CNT_W_DEFAULT,
    parameter  int unsigned WIN_US    = 1,
    parameter  int unsigned SETTLE_US = 2,
    localparam int unsigned CH_W      = $clog2(N_CH)
) (
    input  logic             clk_100Mz,
    input  logic             rst,
    input  logic             clk_1Mz,
    input  logic [N_CH-1:0]  ttl_in,
    input  logic             start,
    input  logic             abort,
    input  logic [N_CH-1:0]  chan_en,
    input  logic [CNT_W-1:0] exp_min,
    input  logic [CNT_W-1:0] exp_max,
    output logic             busy,
    output logic [CH_W-1:0]  ch_sel,
    output logic             res_valid,
    output logic [CH_W-1:0]  res_ch,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_pass,
    output logic             done,
    output logic [N_CH-1:0]  pass_mask
);

    localparam int unsigned T_MAX  = (SETTLE_US > WIN_US) ? SETTLE_US : WIN_US;
    localparam int unsigned TICK_W = $clog2(T_MAX + 1);

    logic [N_CH-1:0]   ttl_meta, ttl_sync;
    logic              clk1_meta, clk1_sync, clk1_hist;
    state_t            state;
    logic [TICK_W-1:0] tcnt;
    logic [N_CH-1:0]   mask_q;
    logic [CNT_W-1:0]  min_q, max_q;
    logic [CH_W-1:0]   ch_prev;
    logic [CNT_W-1:0]  cnt;

    logic              tick_c, pass_c, stop_c, has_next_c;
    logic [CH_W-1:0]   first_ch_c, next_ch_c;

    // Input synchronizers and tick history
    always_ff @(posedge clk_100Mz or posedge rst) begin
        if (rst) begin
            ttl_meta  <= '0;
            ttl_sync  <= '0;
            clk1_meta <= 1'b0;
            clk1_sync <= 1'b0;
            clk1_hist <= 1'b0;
        end else begin
            ttl_meta  <= ttl_in;
            ttl_sync  <= ttl_meta;
            clk1_meta <= clk_1Mz;
            clk1_sync <= clk1_meta;
            clk1_hist <= clk1_sync;
        end
    end

    assign tick_c = ({clk1_hist, clk1_sync} == RISE_EDGE);
    assign pass_c = (cnt >= min_q) && (cnt <= max_q);

`ifdef TTL_SEQ_STOP_ON_FAIL_EN
    assign stop_c = !pass_c;
`else
    assign stop_c = 1'b0;
`endif

    // Lowest enabled channel at start, next higher enabled channel after EVAL
    always_comb begin
        first_ch_c = '0;
        next_ch_c  = '0;
        has_next_c = 1'b0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (chan_en[i]) begin
                first_ch_c = CH_W'(i);
            end
            if (mask_q[i] && (CH_W'(i) > ch_sel)) begin
                next_ch_c  = CH_W'(i);
                has_next_c = 1'b1;
            end
        end
    end

    ttl_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk_100Mz (clk_100Mz),
        .rst       (rst),
        .din       (ttl_sync[ch_sel]),
        .reload    (ch_sel != ch_prev),
        .clr       (state == SETTLE),
        .en        (state == MEASURE),
        .cnt       (cnt)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk_100Mz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            mask_q    <= '0;
            min_q     <= '0;
            max_q     <= '0;
            ch_prev   <= '0;
            busy      <= 1'b0;
            ch_sel    <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_cnt   <= '0;
            res_pass  <= 1'b0;
            done      <= 1'b0;
            pass_mask <= '0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            ch_prev   <= ch_sel;
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            mask_q    <= chan_en;
                            min_q     <= exp_min;
                            max_q     <= exp_max;
                            pass_mask <= '0;
                            tcnt      <= '0;
                            busy      <= 1'b1;
                            if (chan_en != '0) begin
                                ch_sel <= first_ch_c;
                                state  <= SETTLE;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                    SETTLE: begin
                        if (tick_c) begin
                            if (tcnt == TICK_W'(SETTLE_US - 1)) begin
                                tcnt  <= '0;
                                state <= MEASURE;
                            end else begin
                                tcnt <= tcnt + TICK_W'(1);
                            end
                        end
                    end
                    MEASURE: begin
                        if (tick_c) begin
                            if (tcnt == TICK_W'(WIN_US - 1)) begin
                                tcnt  <= '0;
                                state <= EVAL;
                            end else begin
                                tcnt <= tcnt + TICK_W'(1);
                            end
                        end
                    end
                    EVAL: begin
                        res_valid         <= 1'b1;
                        res_ch            <= ch_sel;
                        res_cnt           <= cnt;
                        res_pass          <= pass_c;
                        pass_mask[ch_sel] <= pass_c;
                        if (has_next_c && !stop_c) begin
                            ch_sel <= next_ch_c;
                            state  <= SETTLE;
                        end else begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ttl_test_sequencer.sv
// Self-checking bench for ttl_test_sequencer: table-driven single-channel runs plus
// hand-written multi-channel, abort, reset, start-while-busy and zero-mask sequences.
// Results and done masks are predicted into queues and checked as the DUT emits them.
module tb_ttl_test_sequencer;

    localparam int unsigned N_CH      = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned WIN_US    = 1;
    localparam int unsigned SETTLE_US = 2;

    logic             clk_100Mz = 1'b0;
    logic             rst       = 1'b1;
    logic             clk_1Mz   = 1'b0;
    logic             ttl_line  = 1'b1;
    logic [N_CH-1:0]  ttl_in;
    logic             start     = 1'b0;
    logic             abort     = 1'b0;
    logic [N_CH-1:0]  chan_en   = '0;
    logic [CNT_W-1:0] exp_min   = '0;
    logic [CNT_W-1:0] exp_max   = '0;
    logic             busy, res_valid, res_pass, done;
    logic [1:0]       ch_sel, res_ch;
    logic [CNT_W-1:0] res_cnt;
    logic [N_CH-1:0]  pass_mask;

    assign ttl_in = {N_CH{ttl_line}};

    always #5 clk_100Mz = ~clk_100Mz;

    ttl_test_sequencer #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .WIN_US    (WIN_US),
        .SETTLE_US (SETTLE_US)
    ) dut (
        .clk_100Mz (clk_100Mz),
        .rst       (rst),
        .clk_1Mz   (clk_1Mz),
        .ttl_in    (ttl_in),
        .start     (start),
        .abort     (abort),
        .chan_en   (chan_en),
        .exp_min   (exp_min),
        .exp_max   (exp_max),
        .busy      (busy),
        .ch_sel    (ch_sel),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_cnt   (res_cnt),
        .res_pass  (res_pass),
        .done      (done),
        .pass_mask (pass_mask)
    );

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] cnt;
        logic       pass;
    } res_t;

    typedef struct {
        logic [3:0] en;
        logic [3:0] mn;
        logic [3:0] mx;
        int         n_settle;
        int         n_meas;
        bit         co_settle;
        bit         co_final;
        logic [1:0] ch;
        logic [3:0] cnt;
        bit         pass;
    } vec_t;

    res_t       res_q[$];
    logic [3:0] mask_q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    vec_t       vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] en, input logic [3:0] mn, input logic [3:0] mx,
                                input int ns, input int nm, input bit cs, input bit cf,
                                input logic [1:0] ch, input logic [3:0] cnt, input bit pass);
        vec_t v;
        v.en = en; v.mn = mn; v.mx = mx; v.n_settle = ns; v.n_meas = nm;
        v.co_settle = cs; v.co_final = cf; v.ch = ch; v.cnt = cnt; v.pass = pass;
        return v;
    endfunction

    // Scoreboard monitor: pops predicted results / masks as the DUT produces them
    always @(negedge clk_100Mz) begin
        if (res_valid) begin
            if (res_q.size() == 0) begin
                chk("unexpected_res_valid", 32'(res_valid), 32'd0);
            end else begin
                res_t e;
                e = res_q.pop_front();
                chk("res_ch", 32'(res_ch), 32'(e.ch));
                chk("res_cnt", 32'(res_cnt), 32'(e.cnt));
                chk("res_pass", 32'(res_pass), 32'(e.pass));
            end
        end
        if (done) begin
            done_cnt++;
            if (mask_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                chk("pass_mask_at_done", 32'(pass_mask), 32'(mask_q.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100Mz);
    endtask

    task automatic pulse();
        ttl_line = 1'b0; cyc(2);
        ttl_line = 1'b1; cyc(2);
    endtask

    // One 1 MHz tick, optionally with a falling TTL edge detected in the same cycle
    task automatic tick(input bit with_fall);
        if (with_fall) ttl_line = 1'b0;
        clk_1Mz = 1'b1; cyc(4);
        clk_1Mz = 1'b0; ttl_line = 1'b1; cyc(4);
    endtask

    task automatic start_seq(input logic [3:0] en, input logic [3:0] mn, input logic [3:0] mx);
        chan_en = en; exp_min = mn; exp_max = mx; start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic run_channel(input int ns, input int nm, input bit cs, input bit cf);
        repeat (ns) pulse();
        for (int k = 0; k < int'(SETTLE_US); k++) tick(cs && (k == int'(SETTLE_US) - 1));
        repeat (nm) pulse();
        for (int k = 0; k < int'(WIN_US); k++) tick(cf && (k == int'(WIN_US) - 1));
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while ((done_cnt == d0) && (n < 300)) begin
            cyc(1);
            n++;
        end
        chk("done_seen", 32'(done_cnt > d0), 32'd1);
        cyc(3);
    endtask

    initial begin
        int d0;
        res_t r;

        vecs[0]  = mk(4'b0001, 4'd3, 4'd5, 0,  2, 1'b0, 1'b0, 2'd0, 4'd2,  1'b0);
        vecs[1]  = mk(4'b0010, 4'd3, 4'd5, 3,  3, 1'b0, 1'b0, 2'd1, 4'd3,  1'b1);
        vecs[2]  = mk(4'b0100, 4'd3, 4'd5, 0,  5, 1'b0, 1'b0, 2'd2, 4'd5,  1'b1);
        vecs[3]  = mk(4'b1000, 4'd3, 4'd5, 0,  6, 1'b0, 1'b0, 2'd3, 4'd6,  1'b0);
        vecs[4]  = mk(4'b0001, 4'd3, 4'd5, 0, 40, 1'b0, 1'b0, 2'd0, 4'd15, 1'b0);
        vecs[5]  = mk(4'b0001, 4'd0, 4'd15,0, 40, 1'b0, 1'b0, 2'd0, 4'd15, 1'b1);
        vecs[6]  = mk(4'b0001, 4'd3, 4'd5, 0,  2, 1'b0, 1'b1, 2'd0, 4'd3,  1'b1);
        vecs[7]  = mk(4'b0010, 4'd3, 4'd5, 0,  5, 1'b1, 1'b0, 2'd1, 4'd5,  1'b1);
        vecs[8]  = mk(4'b0001, 4'd5, 4'd3, 0,  4, 1'b0, 1'b0, 2'd0, 4'd4,  1'b0);
        vecs[9]  = mk(4'b0100, 4'd0, 4'd0, 0,  0, 1'b0, 1'b0, 2'd2, 4'd0,  1'b1);
        vecs[10] = mk(4'b0001, 4'd3, 4'd5, 2,  4, 1'b0, 1'b1, 2'd0, 4'd5,  1'b1);

        // Reset state
        cyc(3);
        chk("reset_outputs", 32'({busy, ch_sel, res_valid, res_ch, res_cnt, res_pass, done, pass_mask}), 32'd0);
        rst = 1'b0;
        cyc(4);

        // Table-driven single-channel runs
        for (int i = 0; i < 11; i++) begin
            d0 = done_cnt;
            r.ch = vecs[i].ch; r.cnt = vecs[i].cnt; r.pass = vecs[i].pass;
            res_q.push_back(r);
            mask_q.push_back(vecs[i].pass ? vecs[i].en : 4'b0000);
            start_seq(vecs[i].en, vecs[i].mn, vecs[i].mx);
            chk("busy_after_start", 32'(busy), 32'd1);
            run_channel(vecs[i].n_settle, vecs[i].n_meas, vecs[i].co_settle, vecs[i].co_final);
            wait_done(d0);
            chk("busy_after_done", 32'(busy), 32'd0);
        end

        // Clean two-channel pass: ch0 then ch2
        d0 = done_cnt;
        r = '{ch: 2'd0, cnt: 4'd4, pass: 1'b1}; res_q.push_back(r);
        r = '{ch: 2'd2, cnt: 4'd4, pass: 1'b1}; res_q.push_back(r);
        mask_q.push_back(4'b0101);
        start_seq(4'b0101, 4'd3, 4'd5);
        run_channel(0, 4, 1'b0, 1'b0);
        chk("ch_sel_second", 32'(ch_sel), 32'd2);
        run_channel(0, 4, 1'b0, 1'b0);
        wait_done(d0);

        // Abort during the second channel's MEASURE
        d0 = done_cnt;
        r = '{ch: 2'd0, cnt: 4'd4, pass: 1'b1}; res_q.push_back(r);
        start_seq(4'b0011, 4'd3, 4'd5);
        run_channel(0, 4, 1'b0, 1'b0);
        tick(1'b0); tick(1'b0);
        pulse(); pulse();
        abort = 1'b1; cyc(1); abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pass_mask", 32'(pass_mask), 32'b0001);
        tick(1'b0);
        cyc(10);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));

        // Async reset mid-SETTLE
        start_seq(4'b0100, 4'd3, 4'd5);
        tick(1'b0);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_reset_outputs", 32'({busy, ch_sel, res_valid, res_ch, res_cnt, res_pass, done, pass_mask}), 32'd0);
        chk("mid_reset_res_cnt", 32'(res_cnt), 32'd0);
        cyc(2);
        rst = 1'b0;
        tick(1'b0); pulse(); pulse(); tick(1'b0); tick(1'b0);
        cyc(5);
        chk("no_resume_busy", 32'(busy), 32'd0);

        // Start while busy is ignored
        d0 = done_cnt;
        r = '{ch: 2'd0, cnt: 4'd4, pass: 1'b1}; res_q.push_back(r);
        mask_q.push_back(4'b0001);
        start_seq(4'b0001, 4'd3, 4'd5);
        tick(1'b0);
        start_seq(4'b0010, 4'd0, 4'd0);
        tick(1'b0);
        repeat (4) pulse();
        tick(1'b0);
        wait_done(d0);

        // Zero mask: done two cycles after start
        d0 = done_cnt;
        mask_q.push_back(4'b0000);
        start_seq(4'b0000, 4'd3, 4'd5);
        chk("zero_done_early", 32'(done), 32'd0);
        chk("zero_busy", 32'(busy), 32'd1);
        cyc(1);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy_drop", 32'(busy), 32'd0);
        wait_done(d0);

        // First channel fails; second passes unless stop-on-fail is built in
        d0 = done_cnt;
        r = '{ch: 2'd0, cnt: 4'd2, pass: 1'b0}; res_q.push_back(r);
`ifdef TTL_SEQ_STOP_ON_FAIL_EN
        mask_q.push_back(4'b0000);
`else
        r = '{ch: 2'd1, cnt: 4'd4, pass: 1'b1}; res_q.push_back(r);
        mask_q.push_back(4'b0010);
`endif
        start_seq(4'b0011, 4'd3, 4'd5);
        run_channel(0, 2, 1'b0, 1'b0);
        run_channel(0, 4, 1'b0, 1'b0);
        wait_done(d0);

        cyc(5);
        chk("res_queue_empty", 32'(res_q.size()), 32'd0);
        chk("mask_queue_empty", 32'(mask_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttl_test_sequencer.md
Name: ttl_test_sequencer

Overview:
Sequences a bank of TTL test inputs through one shared falling-edge counter, clocked at 100 MHz and using the 1 MHz strobe as its time base. On start it walks the enabled channels in ascending order. For each channel it waits a settle window, counts falling edges over a measurement window, and checks the count against min/max limits. It then reports a per-channel result and a final pass mask, and sits between the check-unit control logic and the raw TTL test lines.

Parameters:
N_CH, 8, number of TTL channels (2..16)
CNT_W, 8, edge-counter width; the count saturates at 2^CNT_W-1
WIN_US, 1, measurement window length in 1 MHz ticks (>=1)
SETTLE_US, 2, settle window length in 1 MHz ticks after a channel switch (>=1)

Ports:
clk_100Mz  in  1  system clock
rst  in  1  asynchronous reset, active-high
clk_1Mz  in  1  1 MHz time base, sampled in clk_100Mz; tick = detected rising edge
ttl_in  in  N_CH  TTL test lines, asynchronous
start  in  1  single-cycle pulse that begins a sequence
abort  in  1  single-cycle pulse that cancels the sequence
chan_en  in  N_CH  channel enable mask, captured at start
exp_min  in  CNT_W  lower pass limit (inclusive), captured at start
exp_max  in  CNT_W  upper pass limit (inclusive), captured at start
busy  out  1  high from the cycle after an accepted start until DONE exits
ch_sel  out  $clog2(N_CH)  channel currently routed to the counter
res_valid  out  1  one-cycle result strobe
res_ch  out  $clog2(N_CH)  channel of the current result
res_cnt  out  CNT_W  measured count
res_pass  out  1  exp_min <= res_cnt <= exp_max
done  out  1  one-cycle pulse at sequence completion
pass_mask  out  N_CH  per-channel pass bits; unmeasured channels read 0

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, all synchronizers and counters cleared.
- ttl_in passes through a 2-FF synchronizer per channel.
- The selected synchronized line feeds a 1-FF history register; a falling edge is history=1 and current=0.
- The history register is reloaded with the current value on every channel switch, so a switch cannot produce a false edge.
- clk_1Mz passes through a 2-FF synchronizer. tick is the rising edge of the synchronized signal (pattern 01).
- FSM states: IDLE, SETTLE, MEASURE, EVAL, DONE.
- IDLE:
  - On start, capture chan_en, exp_min and exp_max and clear pass_mask.
  - If the captured mask is non-zero, go to SETTLE with ch_sel = lowest enabled channel.
  - If the mask is zero, go to DONE.
  - start while busy is ignored.
- SETTLE: count ticks; after SETTLE_US ticks, clear the edge counter and go to MEASURE. Edges during SETTLE are discarded.
- MEASURE:
  - Count falling edges, saturating at all-ones (no wrap).
  - After WIN_US ticks go to EVAL.
  - An edge in the same cycle as the final tick is counted.
  - An edge in the same cycle as the tick that ends SETTLE is not counted.
- EVAL (exactly 1 cycle):
  - res_valid=1 with res_ch, res_cnt and res_pass.
  - pass_mask[ch] <= res_pass.
  - Next state: SETTLE with the next higher enabled channel, or DONE if none remain.
  - res_ch, res_cnt and res_pass hold until the next EVAL.
- DONE (1 cycle): done=1, busy drops the following cycle, return to IDLE. pass_mask holds until the next accepted start.
- If exp_min > exp_max, every channel fails.
- abort in any non-IDLE state goes to IDLE on the next cycle:
  - no done and no res_valid;
  - pass_mask keeps the results of channels already evaluated.
- abort and start in the same cycle while in IDLE: abort wins and start is ignored.
- Async reset mid-sequence gives the immediate reset state. No sequence resumes after reset; a new start is required.

Optional Feature:
TTL_SEQ_STOP_ON_FAIL_EN
- Defined: an EVAL with res_pass=0 goes directly to DONE. Remaining channels are skipped and their pass_mask bits stay 0; done still pulses.
- Undefined: all enabled channels are always measured.

Decomposition:
- Package ttl_test_pkg:
  - state enum (IDLE, SETTLE, MEASURE, EVAL, DONE);
  - edge-pattern constants FALL_EDGE=2'b10 and RISE_EDGE=2'b01;
  - typedef for the CNT_W count.
- Sub-module ttl_edge_counter: synchronized input, history register, falling-edge detect, saturating counter, with clear and enable inputs.
- ttl_test_sequencer owns the channel mux, tick detection, FSM and result logic.

Test Plan:
- Clean pass: N_CH=4, chan_en=4'b0101, limits 3..5, 4 falling edges per window on ch0 and ch2. Expect two res_valid pulses (ch0 then ch2), each with cnt=4 and pass=1, then done and pass_mask=4'b0101.
- Limit boundaries: edges per window of 2, 3, 5 and 6 with limits 3..5. Expect pass = 0, 1, 1, 0. Edges during SETTLE are never counted.
- Saturation: CNT_W=4, 40 edges in the window. Expect res_cnt=15 with no wrap.
- Tick coincidence: an edge in the same cycle as the final MEASURE tick is counted; an edge in the same cycle as the SETTLE-ending tick is not.
- Abort and reset:
  - abort during the second channel's MEASURE: IDLE next cycle, no done, pass_mask holds only the first channel's bit.
  - rst asserted mid-SETTLE: all outputs 0 immediately.
  - start while busy: ignored.
- Zero mask and stop-on-fail:
  - chan_en=0: done 2 cycles after start, pass_mask=0.
  - With TTL_SEQ_STOP_ON_FAIL_EN and ch0 failing: done follows ch0's EVAL and pass_mask=0.
